// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the data-memory arbiter, its two requesters (CPU MEM stage, DMA/loader)
// and the single-port data memory.
interface dmem_arbiter_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_ack;
  logic        cpu_stall;

  logic        dma_req;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        dma_ack;

  logic        err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    input  mem_rdata, mem_ack,
    output cpu_rdata, cpu_ack, cpu_stall,
    output dma_rdata, dma_ack, err,
    output mem_req, mem_we, mem_addr, mem_wdata
  );

  // Requesters and memory side.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    output mem_rdata, mem_ack,
    input  cpu_rdata, cpu_ack, cpu_stall,
    input  dma_rdata, dma_ack, err,
    input  mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter: CPU vs DMA, one access at a time (IDLE -> BUSY -> DONE),
// with a per-access watchdog and a starvation counter that lets DMA win ties periodically.
module dmem_arbiter #(
  parameter int unsigned MAX_CPU_RUN = 4,
  parameter int unsigned TIMEOUT     = 16
) (
  input logic           clk_i,
  input logic           rst_i,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned RunW = $clog2(MAX_CPU_RUN) + 1;
  localparam int unsigned WdW  = $clog2(TIMEOUT) + 1;
  localparam logic [RunW-1:0] RunMax = RunW'(MAX_CPU_RUN);
  localparam logic [WdW-1:0]  WdLast = WdW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;  // 1 = DMA owns the access
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [RunW-1:0] run_cnt_q, run_cnt_d;
  logic [WdW-1:0]  wd_cnt_q, wd_cnt_d;
  logic            grant_dma;
  logic            done;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    run_cnt_d = run_cnt_q;
    wd_cnt_d  = wd_cnt_q;
    grant_dma = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.cpu_req || bus.dma_req) begin
          grant_dma = bus.dma_req && (!bus.cpu_req || (run_cnt_q == RunMax));
          owner_d   = grant_dma;
          we_d      = grant_dma ? bus.dma_we    : bus.cpu_we;
          addr_d    = grant_dma ? bus.dma_addr  : bus.cpu_addr;
          wdata_d   = grant_dma ? bus.dma_wdata : bus.cpu_wdata;
          // Only contested CPU wins count toward starvation.
          if (grant_dma || !bus.dma_req) begin
            run_cnt_d = '0;
          end else if (run_cnt_q != RunMax) begin
            run_cnt_d = run_cnt_q + RunW'(1);
          end
          wd_cnt_d = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        wd_cnt_d = wd_cnt_q + WdW'(1);
        if (bus.mem_ack) begin
          rdata_d = we_q ? 32'h0 : bus.mem_rdata;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (wd_cnt_q == WdLast) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        wd_cnt_d = '0;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      owner_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rdata_q   <= 32'h0;
      err_q     <= 1'b0;
      run_cnt_q <= '0;
      wd_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      run_cnt_q <= run_cnt_d;
      wd_cnt_q  <= wd_cnt_d;
    end
  end

  assign done          = (state_q == StDone);
  assign bus.mem_req   = (state_q == StBusy);
  assign bus.mem_we    = (state_q == StBusy) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

  assign bus.cpu_ack   = done && !owner_q;
  assign bus.dma_ack   = done && owner_q;
  assign bus.cpu_rdata = (done && !owner_q) ? rdata_q : 32'h0;
  assign bus.dma_rdata = (done && owner_q) ? rdata_q : 32'h0;
  assign bus.err       = done && err_q;
  assign bus.cpu_stall = bus.cpu_req && !bus.cpu_ack;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Arbitrates the single-port data memory between the pipeline MEM stage (CPU port) and a DMA/loader port. Requests from either side are sequenced through a multi-cycle memory handshake, and a stall is raised to the pipeline while a CPU access is outstanding. A watchdog bounds each memory access. A starvation counter guarantees DMA progress under continuous CPU traffic.

## Interface
- `MAX_CPU_RUN`, default 4: consecutive contested CPU grants allowed before the DMA wins a tie.
- `TIMEOUT`, default 16: maximum BUSY cycles waiting for `mem_ack_i` before the access is aborted.
- `clk_i` input 1: single clock; all state changes on the rising edge.
- `rst_i` input 1: asynchronous, active-low reset.
- `cpu_req_i` input 1: CPU access request; held with its address and data until `cpu_ack_o`.
- `cpu_we_i` input 1: 1 = write, 0 = read.
- `cpu_addr_i` input 32: byte address.
- `cpu_wdata_i` input 32: write data.
- `cpu_rdata_o` output 32: read data, valid while `cpu_ack_o` = 1.
- `cpu_ack_o` output 1: one-cycle completion pulse.
- `cpu_stall_o` output 1: combinational, `cpu_req_i & ~cpu_ack_o`.
- `dma_req_i`, `dma_we_i`, `dma_addr_i[31:0]`, `dma_wdata_i[31:0]`, `dma_rdata_o[31:0]`, `dma_ack_o`: same semantics as the CPU port.
- `err_o` output 1: asserted together with the ack pulse when the access timed out.
- `mem_req_o` output 1: memory request, held until ack or abort.
- `mem_we_o` output 1: memory write enable.
- `mem_addr_o` output 32: registered address of the granted request.
- `mem_wdata_o` output 32: registered write data of the granted request.
- `mem_rdata_i` input 32: memory read data, sampled when `mem_ack_i` = 1.
- `mem_ack_i` input 1: memory completion, sampled only in BUSY.

## Operation
- FSM has three states: IDLE, BUSY and DONE. Reset state is IDLE.
- **IDLE:**
  - If no request is present, stay in IDLE.
  - Otherwise grant one requester, latch owner, we, addr and wdata into registers, and go to BUSY.
- **Grant rule:**
  - With a single requester, that requester wins.
  - With both requesting, the CPU wins unless `run_cnt` == `MAX_CPU_RUN`, in which case the DMA wins.
- **run_cnt** (width clog2(`MAX_CPU_RUN`)+1):
  - +1 on a CPU grant made while `dma_req_i` = 1.
  - Cleared on any DMA grant.
  - Cleared on a CPU grant made while `dma_req_i` = 0.
  - Saturates at `MAX_CPU_RUN`.
- **BUSY:**
  - `mem_req_o` = 1; `mem_we_o`, `mem_addr_o` and `mem_wdata_o` are driven from the latched registers.
  - `wd_cnt` increments each BUSY cycle.
  - On `mem_ack_i` = 1: latch `mem_rdata_i`, clear the error flag, go to DONE.
  - On `wd_cnt` == `TIMEOUT`-1 without ack: latch rdata = 0, set the error flag, go to DONE.
  - `mem_ack_i` and timeout in the same cycle: the ack wins, no error.
- **DONE:**
  - Owner's ack = 1 for exactly one cycle, with its rdata and `err_o`. The other port's ack stays 0.
  - `mem_req_o` = 0. `wd_cnt` is cleared.
  - Next state is IDLE.
- **Requester rule:** deassert req, or present the next request, on the edge after the ack is seen. A req still high in the IDLE following DONE is treated as a new request.
- For writes, rdata outputs are 0 during the ack.
- Request changes while not in IDLE are ignored; the latched copy is authoritative.
- **Reset asserted at any time:**
  - FSM returns to IDLE; `run_cnt`, `wd_cnt` and all registers are cleared.
  - `mem_req_o` drops asynchronously.
  - An in-flight access is abandoned without an ack.

## Timing
- Reset values: all outputs 0, except `cpu_stall_o`, which follows `cpu_req_i`.
- Minimum access is 3 cycles, request to ack: IDLE grant, BUSY with `mem_ack_i` in its first cycle, then DONE.
- General latency is 2 + N cycles, where N is the number of BUSY cycles including the ack cycle; 1 ≤ N ≤ `TIMEOUT`.
- Back-to-back throughput is one access per 3 cycles at best; there is no overlap of accesses.
- `mem_req_o` rises on the edge entering BUSY and falls on the edge entering DONE.
- `cpu_stall_o` is high from the cycle the CPU raises req through the cycle before `cpu_ack_o`. It is low in the ack cycle so the pipeline advances on that edge.

## Test plan
- **Single CPU read:** addr 0x10, memory acks on the 1st BUSY cycle with 0xDEADBEEF → `cpu_ack_o` on cycle 3 with `cpu_rdata_o` = 0xDEADBEEF, `err_o` = 0, `cpu_stall_o` high for cycles 1–2.
- **DMA write, slow memory:** addr 0x20, data 0x5A5A5A5A, ack after 5 BUSY cycles → `mem_we_o` = 1 and `mem_addr_o` = 0x20 held for 5 cycles, `dma_ack_o` on cycle 7, `dma_rdata_o` = 0.
- **Both requesting continuously, `MAX_CPU_RUN`=4:** grant order is C,C,C,C,D,C,C,C,C,D, and `run_cnt` clears after each D.
- **Timeout:** memory never acks, `TIMEOUT`=16 → ack plus `err_o` = 1 and rdata = 0 at cycle 18 (request to ack), `mem_req_o` low in DONE. Also drive ack exactly on the 16th BUSY cycle → normal completion, `err_o` = 0.
- **Reset mid-BUSY:** assert `rst_i` = 0 in the 3rd BUSY cycle → `mem_req_o` drops asynchronously, no ack is issued, and after release a fresh CPU read completes normally in 3 cycles.
- **Request held through DONE:** CPU keeps req high one cycle past the ack → a second, independent access is granted in the following IDLE.
